ecall_io_sequencer: RTL
=======================

Name: ecall_io_sequencer

Overview:
- Sequences the `ecall`-based I/O service for the single-cycle RISC-V core.
- On an `ecall` whose a7 selects an I/O service, it stalls the PC and waits for a debounced press-and-release of the confirm button.
- It then either returns switch data for write-back into a0 or latches a0 onto the LED / 7-segment outputs.
- It sits beside the control unit and register file, and drives the IF stall and the a0 write-back path.

Parameters:
- DEBOUNCE_CYCLES, 100000: consecutive stable synced cycles required to accept a button level change (benches use 4).
- CNT_W, 17: debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Instruction  in  32  current instruction from IF.
- rega7  in  32  register file a7 value.
- rega0  in  32  register file a0 value.
- switches  in  16  board DIP switches.
- confirm_btn  in  1  raw confirm push button, asynchronous.
- stall  out  1  1 holds the PC and blocks all register and memory writes this cycle.
- io_wen  out  1  one-cycle strobe: write io_wdata into a0.
- io_wdata  out  32  read-service result; 0 when io_wen=0.
- led_out  out  16  registered LED value.
- seg_value  out  32  registered 7-segment display value.
- halted  out  1  1 after the halt service, until reset.

Behaviour:
- ecall detect: Instruction == 32'h00000073. Other encodings are ignored.
- Service codes (a7):
  - 0: zero-extend switches[15:0].
  - 1: sign-extend switches[7:0].
  - 2: zero-extend switches[7:0].
  - 3: sign-extend switches[15:0].
  - 4: led_out <= rega0[15:0].
  - 5: seg_value <= rega0.
  - 10: halt.
  - Any other a7: ecall is a NOP (no stall, no effect).
- Button sync: confirm_btn passes through 2 flip-flops before use. Sync FFs reset to 0.
- Debounce counter: clears on every state change and whenever the synced level differs from the level awaited in the current state. Otherwise it increments, saturating at DEBOUNCE_CYCLES.
- State IDLE:
  - ecall with a7 in 0..5: latch op_q <= a7[2:0], go to WAIT_PRESS.
  - ecall with a7 == 10: go to HALT.
  - Otherwise stay in IDLE.
- State WAIT_PRESS: awaits synced=1. When the counter reaches DEBOUNCE_CYCLES, go to WAIT_RELEASE.
- State WAIT_RELEASE: awaits synced=0. When the counter reaches DEBOUNCE_CYCLES, go to COMMIT.
- State COMMIT (exactly 1 cycle):
  - ops 0..3: io_wen=1, io_wdata from switches sampled this cycle.
  - op 4: led_out <= rega0[15:0].
  - op 5: seg_value <= rega0.
  - Always returns to IDLE.
- State HALT: absorbing; halted=1. Only reset exits.
- stall (combinational):
  - 1 in IDLE when an ecall with a7 in {0..5, 10} is present.
  - 1 in WAIT_PRESS, WAIT_RELEASE and HALT.
  - 0 in COMMIT, so the PC advances past the ecall at the end of the COMMIT cycle.
- Latency: minimum 1 (IDLE) + DEBOUNCE_CYCLES + DEBOUNCE_CYCLES + 1 (COMMIT) cycles from ecall arrival to PC advance, plus 2 sync cycles per button edge.
- Button already held at ecall entry: the press is counted immediately, but a full debounced release is still required. Exactly one service per press/release.
- Glitches shorter than DEBOUNCE_CYCLES: no state change.
- rega0 and switches are sampled in COMMIT, not at entry. The core is stalled, so both are stable.
- Back-to-back ecalls: the next ecall is evaluated in the IDLE cycle that follows COMMIT.
- Reset (rst_n=0 at a clock edge, in any state including mid-service):
  - state <= IDLE, counter <= 0, op_q <= 0.
  - led_out <= 0, seg_value <= 0, halted <= 0.
  - stall=0 and io_wen=0 while rst_n=0.

Test Plan (DEBOUNCE_CYCLES=4):
- Read switches, zero-extended: ecall, a7=0, switches=16'hA5F0; press 6 cycles, release 6 cycles.
  - Required: stall=1 from the ecall cycle until COMMIT.
  - Required: one io_wen pulse with io_wdata=32'h0000A5F0, then stall=0.
- Read low byte, sign-extended: ecall, a7=1, switches=16'h0080.
  - Required: io_wdata=32'hFFFFFF80.
  - Repeat with a7=2: io_wdata=32'h00000080.
- LED and 7-segment writes:
  - ecall, a7=4, a0=32'h1234BEEF, press/release: led_out=16'hBEEF, io_wen never 1.
  - ecall, a7=5, a0=32'h00C0FFEE: seg_value=32'h00C0FFEE.
- Bounce rejection: ecall, a7=0, button toggles every 2 cycles for 20 cycles, then stays low.
  - Required: no COMMIT; stall stays 1.
  - A subsequent clean press/release yields exactly one io_wen.
- Halt and NOP services:
  - ecall, a7=7: stall=0 throughout, no outputs change.
  - ecall, a7=10: stall=1 and halted=1 indefinitely, even across button presses.
  - rst_n=0 for 1 clock: stall=0, halted=0.
- Reset mid-service: a7=4 ecall, assert rst_n=0 during WAIT_RELEASE.
  - Required: led_out=0, state IDLE, no io_wen.
  - Required: with the ecall still presented after reset, stall=1 again.

Source files
------------

// File: rtl/ecall_io_sequencer.sv
// ecall I/O service sequencer: stalls the core on an I/O ecall, waits for a
// debounced confirm press/release, then returns switch data or drives LED/7-seg.
module ecall_io_sequencer #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [31:0] Instruction,
  input  logic [31:0] rega7,
  input  logic [31:0] rega0,
  input  logic [15:0] switches,
  input  logic        confirm_btn,
  output logic        stall,
  output logic        io_wen,
  output logic [31:0] io_wdata,
  output logic [15:0] led_out,
  output logic [31:0] seg_value,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PRESS,
    S_WAIT_RELEASE,
    S_COMMIT,
    S_HALT
  } state_t;

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             sync1;
  logic             sync2;
  logic             is_ecall;
  logic             svc_io;
  logic             svc_halt;
  logic             awaited;
  logic             level_ok;
  logic             debounced;

  // Read services 0..3: zero/sign extension of the switch bank.
  function automatic logic [31:0] ext_switches(input logic [1:0] op, input logic [15:0] sw);
    case (op)
      2'd0:    ext_switches = {16'h0000, sw};
      2'd1:    ext_switches = {{24{sw[7]}}, sw[7:0]};
      2'd2:    ext_switches = {24'h000000, sw[7:0]};
      2'd3:    ext_switches = {{16{sw[15]}}, sw};
      default: ext_switches = 32'h0000_0000;
    endcase
  endfunction

  // Service decode and debounce qualification.
  always_comb begin
    is_ecall  = (Instruction == 32'h0000_0073);
    svc_io    = is_ecall && (rega7 < 32'd6);
    svc_halt  = is_ecall && (rega7 == 32'd10);
    awaited   = (state == S_WAIT_PRESS);
    level_ok  = (sync2 == awaited);
    // Counter reaching DEBOUNCE_CYCLES on this edge means the level held that long.
    debounced = level_ok && (cnt == DB_LAST);
  end

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= confirm_btn;
      sync2 <= sync1;
    end
  end

  // Service FSM with debounce counter and registered display/halt outputs.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= 3'd0;
      led_out   <= 16'h0000;
      seg_value <= 32'h0000_0000;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (svc_io) begin
            op_q  <= rega7[2:0];
            state <= S_WAIT_PRESS;
          end else if (svc_halt) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT_PRESS, S_WAIT_RELEASE: begin
          if (debounced) begin
            cnt   <= '0;
            state <= (state == S_WAIT_PRESS) ? S_WAIT_RELEASE : S_COMMIT;
          end else if (!level_ok) begin
            cnt <= '0;
          end else if (cnt != DB_MAX) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt <= cnt;
          end
        end
        S_COMMIT: begin
          cnt <= '0;
          if (op_q == 3'd4) begin
            led_out <= rega0[15:0];
          end else if (op_q == 3'd5) begin
            seg_value <= rega0;
          end else begin
            led_out <= led_out;
          end
          state <= S_IDLE;
        end
        S_HALT: begin
          cnt    <= '0;
          halted <= 1'b1;
          state  <= S_HALT;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall and write-back strobe; COMMIT releases the PC in the same cycle.
  always_comb begin
    stall    = 1'b0;
    io_wen   = 1'b0;
    io_wdata = 32'h0000_0000;
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      case (state)
        S_IDLE:         stall = svc_io || svc_halt;
        S_WAIT_PRESS:   stall = 1'b1;
        S_WAIT_RELEASE: stall = 1'b1;
        S_HALT:         stall = 1'b1;
        S_COMMIT: begin
          stall = 1'b0;
          if (op_q <= 3'd3) begin
            io_wen   = 1'b1;
            io_wdata = ext_switches(op_q[1:0], switches);
          end else begin
            io_wen = 1'b0;
          end
        end
        default:        stall = 1'b0;
      endcase
    end
  end

endmodule
